// File: rtl/autocorr_sched.sv
// Sequencer for the AutoCorr period-detection engine: arms the engine, captures
// three period readings at the adc_clk rate, validates their spread and tracks lock.
module autocorr_sched #(
  parameter int unsigned RST_CYCLES      = 4,
  parameter int unsigned TIMEOUT_SAMPLES = 4096,
  parameter int unsigned TOL             = 4,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned HOLD_LOSS       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic        adc_clk,
  input  logic        dc_valid,
  input  logic [15:0] ac_period,
  input  logic        ac_stable,
  output logic        ac_en,
  output logic [15:0] period_out,
  output logic        period_valid,
  output logic        locked,
  output logic        busy,
  output logic [1:0]  err_code
);

  localparam int unsigned PW    = 16;
  localparam int unsigned ARM_W = ($clog2(RST_CYCLES) > 0) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned TO_W  = ($clog2(TIMEOUT_SAMPLES) > 0) ? $clog2(TIMEOUT_SAMPLES) : 1;
  localparam int unsigned RT_W  = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned LS_W  = ($clog2(HOLD_LOSS) > 0) ? $clog2(HOLD_LOSS) : 1;

  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_SAMPLES - 1);
  localparam logic [RT_W-1:0]  RT_LAST  = RT_W'(MAX_RETRY - 1);
  localparam logic [LS_W-1:0]  LS_LAST  = LS_W'(HOLD_LOSS - 1);
  localparam logic [PW-1:0]    TOL_V    = PW'(TOL);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RETRY   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_SAMPLE,
    S_CHECK,
    S_REPORT,
    S_HOLD,
    S_ERROR
  } state_t;

  state_t            state_q;
  logic              adc_prev_q;
  logic [ARM_W-1:0]  arm_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [RT_W-1:0]   retry_q;
  logic [LS_W-1:0]   loss_q;
  logic [1:0]        slot_q;
  logic [PW-1:0]     cap_q [3];

  logic              ac_en_q;
  logic [PW-1:0]     period_out_q;
  logic              period_valid_q;
  logic              locked_q;
  logic              busy_q;
  logic [1:0]        err_code_q;

  logic              adc_fe;
  logic              dc_lost;
  logic [PW-1:0]     cap_hi;
  logic [PW-1:0]     cap_lo;
  logic [PW-1:0]     cap_med;
  logic [PW-1:0]     spread;
  logic [PW-1:0]     hold_diff;

  assign adc_fe  = adc_prev_q & ~adc_clk;
  assign dc_lost = ~dc_valid &
                   ((state_q == S_WAIT) || (state_q == S_SAMPLE) ||
                    (state_q == S_CHECK) || (state_q == S_HOLD));

  // Max, min and median of the three captures, plus drift from the locked period.
  always_comb begin
    logic ge_ab;
    logic ge_bc;
    logic ge_ac;
    ge_ab   = cap_q[0] >= cap_q[1];
    ge_bc   = cap_q[1] >= cap_q[2];
    ge_ac   = cap_q[0] >= cap_q[2];
    cap_hi  = ge_ab ? (ge_ac ? cap_q[0] : cap_q[2]) : (ge_bc ? cap_q[1] : cap_q[2]);
    cap_lo  = ge_ab ? (ge_bc ? cap_q[2] : cap_q[1]) : (ge_ac ? cap_q[2] : cap_q[0]);
    cap_med = cap_q[0];
    if (ge_ab) begin
      if (ge_bc)      cap_med = cap_q[1];
      else if (ge_ac) cap_med = cap_q[2];
      else            cap_med = cap_q[0];
    end else begin
      if (ge_ac)      cap_med = cap_q[0];
      else if (ge_bc) cap_med = cap_q[2];
      else            cap_med = cap_q[1];
    end
    spread    = cap_hi - cap_lo;
    hold_diff = (ac_period >= period_out_q) ? (ac_period - period_out_q)
                                            : (period_out_q - ac_period);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      adc_prev_q     <= 1'b0;
      arm_cnt_q      <= '0;
      to_cnt_q       <= '0;
      retry_q        <= '0;
      loss_q         <= '0;
      slot_q         <= '0;
      for (int i = 0; i < 3; i++) cap_q[i] <= '0;
      ac_en_q        <= 1'b0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      busy_q         <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      adc_prev_q     <= adc_clk;
      period_valid_q <= 1'b0;
      if (stop) begin
        state_q  <= S_IDLE;
        ac_en_q  <= 1'b0;
        locked_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (dc_lost) begin
        // Upstream DC removal dropped out: hold the engine in reset and re-arm.
        state_q   <= S_ARM;
        ac_en_q   <= 1'b0;
        locked_q  <= 1'b0;
        arm_cnt_q <= '0;
        loss_q    <= '0;
        slot_q    <= '0;
        for (int i = 0; i < 3; i++) cap_q[i] <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_ERROR: begin
            if (start) begin
              state_q    <= S_ARM;
              err_code_q <= ERR_NONE;
              retry_q    <= '0;
              arm_cnt_q  <= '0;
              locked_q   <= 1'b0;
              ac_en_q    <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
          S_ARM: begin
            if (arm_cnt_q != ARM_LAST) begin
              arm_cnt_q <= arm_cnt_q + ARM_W'(1);
            end else if (dc_valid) begin
              state_q  <= S_WAIT;
              ac_en_q  <= 1'b1;
              to_cnt_q <= '0;
            end
          end
          S_WAIT: begin
            if (adc_fe) begin
              if (ac_stable) begin
                state_q <= S_SAMPLE;
                slot_q  <= '0;
              end else if (to_cnt_q == TO_LAST) begin
                state_q    <= S_ERROR;
                err_code_q <= ERR_TIMEOUT;
                ac_en_q    <= 1'b0;
                busy_q     <= 1'b0;
              end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
              end
            end
          end
          S_SAMPLE: begin
            if (adc_fe) begin
              if (!ac_stable) begin
                state_q  <= S_WAIT;
                to_cnt_q <= '0;
                slot_q   <= '0;
                for (int i = 0; i < 3; i++) cap_q[i] <= '0;
              end else if (ac_period != '0) begin
                cap_q[slot_q] <= ac_period;
                if (slot_q == 2'd2) state_q <= S_CHECK;
                else                slot_q  <= slot_q + 2'd1;
              end
            end
          end
          S_CHECK: begin
            slot_q <= '0;
            for (int i = 0; i < 3; i++) cap_q[i] <= '0;
            if (spread <= TOL_V) begin
              state_q        <= S_REPORT;
              period_out_q   <= cap_med;
              period_valid_q <= 1'b1;
              locked_q       <= 1'b1;
              retry_q        <= '0;
            end else if (retry_q == RT_LAST) begin
              state_q    <= S_ERROR;
              err_code_q <= ERR_RETRY;
              ac_en_q    <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              state_q  <= S_WAIT;
              retry_q  <= retry_q + RT_W'(1);
              to_cnt_q <= '0;
            end
          end
          S_REPORT: begin
            if (continuous) begin
              state_q <= S_HOLD;
              loss_q  <= '0;
            end else begin
              state_q <= S_IDLE;
              ac_en_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          S_HOLD: begin
            // Track the locked period; relock on drift, re-acquire on sustained loss.
            if (adc_fe) begin
              if (ac_stable) begin
                if (hold_diff > TOL_V) begin
                  state_q   <= S_ARM;
                  locked_q  <= 1'b0;
                  ac_en_q   <= 1'b0;
                  arm_cnt_q <= '0;
                end else begin
                  loss_q <= '0;
                end
              end else if (loss_q == LS_LAST) begin
                state_q  <= S_WAIT;
                locked_q <= 1'b0;
                to_cnt_q <= '0;
                loss_q   <= '0;
              end else begin
                loss_q <= loss_q + LS_W'(1);
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            ac_en_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ac_en        = ac_en_q;
  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign busy         = busy_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_autocorr_sched.sv
// Directed bench for autocorr_sched: table of capture triples plus hand-written
// sequences for timeout, hold tracking, dc_valid loss, stop and reset.
module tb_autocorr_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        continuous;
  logic        adc_clk;
  logic        dc_valid;
  logic [15:0] ac_period;
  logic        ac_stable;
  logic        ac_en;
  logic [15:0] period_out;
  logic        period_valid;
  logic        locked;
  logic        busy;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_err    = 0;
  int pv_cnt   = 0;
  int pv_run   = 0;
  int pv_max   = 0;

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [15:0] p2;
    logic        ok;
    logic [15:0] exp_period;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t tbl [7];

  autocorr_sched #(.TIMEOUT_SAMPLES(1000)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .continuous   (continuous),
    .adc_clk      (adc_clk),
    .dc_valid     (dc_valid),
    .ac_period    (ac_period),
    .ac_stable    (ac_stable),
    .ac_en        (ac_en),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .busy         (busy),
    .err_code     (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 20 clk periods per adc period; adc edges land on clk falling edges
  initial begin
    adc_clk = 1'b0;
    forever #100 adc_clk = ~adc_clk;
  end

  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      pv_cnt = pv_cnt + 1;
      pv_run = pv_run + 1;
      if (pv_run > pv_max) pv_max = pv_run;
    end else begin
      pv_run = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present engine outputs, let one adc falling edge consume them, return mid-cycle.
  task automatic feed(input logic s, input logic [15:0] p);
    ac_stable = s;
    ac_period = p;
    @(negedge adc_clk);
    #17;
  endtask

  task automatic do_start(input string name);
    int n;
    @(negedge adc_clk);
    #17;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!ac_en && n < 100) begin
      n = n + 1;
      @(negedge clk);
    end
    chk({name, " arm_low_cycles"}, 32'(n), 32'd4);
  endtask

  task automatic wait_pv(input int base, input string name);
    int k;
    k = 0;
    while (pv_cnt == base && k < 3000) begin
      @(negedge clk);
      k = k + 1;
    end
    chk({name, " pv_seen"}, 32'(pv_cnt - base), 32'd1);
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    int att;
    int n;

    tbl[0] = '{p0: 16'd256,   p1: 16'd256,   p2: 16'd256,   ok: 1'b1, exp_period: 16'd256,   exp_err: 2'b00};
    tbl[1] = '{p0: 16'd255,   p1: 16'd258,   p2: 16'd256,   ok: 1'b1, exp_period: 16'd256,   exp_err: 2'b00};
    tbl[2] = '{p0: 16'd100,   p1: 16'd104,   p2: 16'd102,   ok: 1'b1, exp_period: 16'd102,   exp_err: 2'b00};
    tbl[3] = '{p0: 16'd100,   p1: 16'd105,   p2: 16'd102,   ok: 1'b0, exp_period: 16'd0,     exp_err: 2'b10};
    tbl[4] = '{p0: 16'd250,   p1: 16'd256,   p2: 16'd262,   ok: 1'b0, exp_period: 16'd0,     exp_err: 2'b10};
    tbl[5] = '{p0: 16'd65535, p1: 16'd65531, p2: 16'd65533, ok: 1'b1, exp_period: 16'd65533, exp_err: 2'b00};
    tbl[6] = '{p0: 16'd7,     p1: 16'd3,     p2: 16'd5,     ok: 1'b1, exp_period: 16'd5,     exp_err: 2'b00};

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    dc_valid = 1'b1; ac_stable = 1'b0; ac_period = 16'd0;
    repeat (5) @(negedge clk);
    chk("reset ac_en", 32'(ac_en), 32'd0);
    chk("reset period_out", 32'(period_out), 32'd0);
    chk("reset period_valid", 32'(period_valid), 32'd0);
    chk("reset locked", 32'(locked), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single measurement: stable rises after 50 adc edges at period 256
    base = pv_cnt;
    do_start("first");
    chk("first busy", 32'(busy), 32'd1);
    repeat (50) feed(1'b0, 16'd256);
    chk("first no early pv", 32'(pv_cnt - base), 32'd0);
    repeat (4) feed(1'b1, 16'd256);
    repeat (3) @(negedge clk);
    chk("first pv_count", 32'(pv_cnt - base), 32'd1);
    chk("first period_out", 32'(period_out), 32'd256);
    chk("first locked", 32'(locked), 32'd1);
    chk("first busy after report", 32'(busy), 32'd0);
    chk("first ac_en after report", 32'(ac_en), 32'd0);

    // Table of capture triples in single-measurement mode
    for (int v = 0; v < 7; v++) begin
      base = pv_cnt;
      ac_stable = 1'b0;
      do_start($sformatf("v%0d", v));
      att = tbl[v].ok ? 1 : 3;
      for (int a = 0; a < att; a++) begin
        feed(1'b1, tbl[v].p0);
        feed(1'b1, tbl[v].p0);
        feed(1'b1, tbl[v].p1);
        feed(1'b1, tbl[v].p2);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d pv_count", v), 32'(pv_cnt - base), 32'(tbl[v].ok));
      if (tbl[v].ok) chk($sformatf("v%0d period_out", v), 32'(period_out), 32'(tbl[v].exp_period));
      chk($sformatf("v%0d err_code", v), 32'(err_code), 32'(tbl[v].exp_err));
      chk($sformatf("v%0d locked", v), 32'(locked), 32'(tbl[v].ok));
      chk($sformatf("v%0d busy", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d ac_en", v), 32'(ac_en), 32'd0);
    end

    // Zero periods are skipped while sampling
    base = pv_cnt;
    ac_stable = 1'b0;
    do_start("zero");
    feed(1'b1, 16'd300);
    feed(1'b1, 16'd300);
    feed(1'b1, 16'd0);
    feed(1'b1, 16'd0);
    feed(1'b1, 16'd301);
    chk("zero no pv after two captures", 32'(pv_cnt - base), 32'd0);
    feed(1'b1, 16'd302);
    repeat (3) @(negedge clk);
    chk("zero pv_count", 32'(pv_cnt - base), 32'd1);
    chk("zero period_out", 32'(period_out), 32'd301);

    // Stability loss in SAMPLE discards the partial capture
    base = pv_cnt;
    ac_stable = 1'b0;
    do_start("drop");
    feed(1'b1, 16'd500);
    feed(1'b1, 16'd500);
    feed(1'b0, 16'd500);
    feed(1'b1, 16'd600);
    feed(1'b1, 16'd600);
    feed(1'b1, 16'd601);
    feed(1'b1, 16'd602);
    repeat (3) @(negedge clk);
    chk("drop pv_count", 32'(pv_cnt - base), 32'd1);
    chk("drop period_out", 32'(period_out), 32'd601);

    // Stable timeout after exactly 1000 adc falling edges
    ac_stable = 1'b0;
    do_start("timeout");
    for (int i = 0; i < 999; i++) begin
      @(negedge adc_clk);
      #17;
    end
    chk("timeout err before", 32'(err_code), 32'd0);
    chk("timeout busy before", 32'(busy), 32'd1);
    @(negedge adc_clk);
    chk("timeout err at edge", 32'(err_code), 32'd0);
    #10;
    chk("timeout err_code", 32'(err_code), 32'd1);
    chk("timeout busy", 32'(busy), 32'd0);
    chk("timeout ac_en", 32'(ac_en), 32'd0);
    do_start("rearm");
    chk("rearm err cleared", 32'(err_code), 32'd0);
    chk("rearm busy", 32'(busy), 32'd1);
    pulse_stop();
    chk("rearm stop busy", 32'(busy), 32'd0);

    // Continuous tracking: lock at 512
    continuous = 1'b1;
    base = pv_cnt;
    ac_stable = 1'b0;
    do_start("cont");
    repeat (4) feed(1'b1, 16'd512);
    repeat (3) @(negedge clk);
    chk("cont pv_count", 32'(pv_cnt - base), 32'd1);
    chk("cont period_out", 32'(period_out), 32'd512);
    chk("cont locked", 32'(locked), 32'd1);
    chk("cont busy", 32'(busy), 32'd1);
    chk("cont ac_en", 32'(ac_en), 32'd1);
    feed(1'b1, 16'd514);
    chk("hold small drift locked", 32'(locked), 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold start ignored ac_en", 32'(ac_en), 32'd1);
    chk("hold start ignored locked", 32'(locked), 32'd1);
    repeat (7) feed(1'b0, 16'd0);
    feed(1'b1, 16'd512);
    chk("hold loss7 locked", 32'(locked), 32'd1);
    repeat (7) feed(1'b0, 16'd0);
    chk("hold loss7b locked", 32'(locked), 32'd1);
    base = pv_cnt;
    feed(1'b0, 16'd0);
    chk("hold loss8 locked", 32'(locked), 32'd0);
    chk("hold loss8 ac_en", 32'(ac_en), 32'd1);
    chk("hold loss8 busy", 32'(busy), 32'd1);
    repeat (4) feed(1'b1, 16'd512);
    repeat (3) @(negedge clk);
    chk("relock pv_count", 32'(pv_cnt - base), 32'd1);
    chk("relock locked", 32'(locked), 32'd1);

    // Drift to 400 forces a full re-arm
    base = pv_cnt;
    ac_stable = 1'b1;
    ac_period = 16'd400;
    @(negedge adc_clk);
    #10;
    chk("drift locked", 32'(locked), 32'd0);
    n = 0;
    while (!ac_en && n < 100) begin
      n = n + 1;
      #10;
    end
    chk("drift arm_low_cycles", 32'(n), 32'd4);
    wait_pv(base, "drift");
    @(negedge clk);
    chk("drift period_out", 32'(period_out), 32'd400);
    chk("drift relocked", 32'(locked), 32'd1);

    // dc_valid loss in HOLD
    repeat (3) @(negedge clk);
    dc_valid = 1'b0;
    @(negedge clk);
    chk("dcloss ac_en", 32'(ac_en), 32'd0);
    chk("dcloss locked", 32'(locked), 32'd0);
    chk("dcloss busy", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    chk("dcloss ac_en held", 32'(ac_en), 32'd0);
    base = pv_cnt;
    dc_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("dcloss ac_en restored", 32'(ac_en), 32'd1);
    wait_pv(base, "dcloss");
    repeat (2) @(negedge clk);
    chk("dcloss relocked", 32'(locked), 32'd1);
    pulse_stop();
    chk("stop hold locked", 32'(locked), 32'd0);
    chk("stop hold busy", 32'(busy), 32'd0);
    chk("stop hold ac_en", 32'(ac_en), 32'd0);
    continuous = 1'b0;

    // stop in the middle of SAMPLE
    base = pv_cnt;
    ac_stable = 1'b0;
    do_start("stopsmp");
    feed(1'b1, 16'd700);
    feed(1'b1, 16'd700);
    pulse_stop();
    chk("stopsmp busy", 32'(busy), 32'd0);
    chk("stopsmp ac_en", 32'(ac_en), 32'd0);
    chk("stopsmp locked", 32'(locked), 32'd0);
    repeat (4) feed(1'b1, 16'd700);
    chk("stopsmp no pv", 32'(pv_cnt - base), 32'd0);

    // rst together with start while waiting for stable
    ac_stable = 1'b0;
    do_start("rstwait");
    repeat (20) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rstwait ac_en", 32'(ac_en), 32'd0);
    chk("rstwait period_out", 32'(period_out), 32'd0);
    chk("rstwait locked", 32'(locked), 32'd0);
    chk("rstwait busy", 32'(busy), 32'd0);
    chk("rstwait err_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstwait start ignored busy", 32'(busy), 32'd0);
    chk("rstwait start ignored ac_en", 32'(ac_en), 32'd0);

    chk("period_valid pulse width", 32'(pv_max), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/autocorr_sched.md
Name: autocorr_sched

Overview:
Controller that sequences the AutoCorr period-detection engine. It is clocked at 200 MHz and paced by falling edges of the 10 MHz adc_clk. It arms the engine and waits for stable, then captures three period readings and checks that they agree. An accepted period is reported as the median with a valid pulse; in continuous mode the block keeps tracking and relocks when the period drifts, the engine drops out, or the DC-removal stage drops out.

Parameters:
RST_CYCLES, 4, clk cycles ac_en is held low to reset the engine on every arm
TIMEOUT_SAMPLES, 4096, adc_clk falling edges allowed in WAIT_STABLE before timeout
TOL, 4, max spread (max-min) of 3 captures; max drift tolerated in HOLD
MAX_RETRY, 3, consecutive CHECK failures before error
HOLD_LOSS, 8, consecutive adc edges with ac_stable=0 in HOLD before unlock

Ports:
clk  in  1  200 MHz system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; honoured only in IDLE or ERROR
stop  in  1  one-cycle pulse; forces IDLE from any state
continuous  in  1  1 = track after lock (HOLD); 0 = single measurement
adc_clk  in  1  10 MHz sample clock, derived from the same source as clk
dc_valid  in  1  DC-removal output valid (DC_Removal.en)
ac_period  in  16  AutoCorr period output
ac_stable  in  1  AutoCorr stable flag
ac_en  out  1  AutoCorr enable; low = engine held in reset
period_out  out  16  accepted period (median of 3)
period_valid  out  1  one-cycle pulse when period_out updates
locked  out  1  high from REPORT until unlock, stop or reset
busy  out  1  high in every state except IDLE and ERROR
err_code  out  2  00 none, 01 stable timeout, 10 retries exhausted

Behaviour:
- Reset: state=IDLE; all outputs 0 (ac_en=0, period_out=0, period_valid=0, locked=0, busy=0, err_code=00); counters and capture buffer cleared. rst overrides every other input.
- Edge detect: adc_prev is registered every clk; adc_fe = adc_prev & ~adc_clk. All sample-rate events act on the clk cycle in which adc_fe=1.
- IDLE: ac_en=0. On start, go to ARM, clear err_code, clear retry count.
- ARM: ac_en=0 for exactly RST_CYCLES clk cycles, then stay until dc_valid=1. Then set ac_en=1, clear the timeout counter and go to WAIT_STABLE.
- WAIT_STABLE: count adc_fe.
  - If ac_stable=1 on an adc_fe, go to SAMPLE.
  - If the count reaches TIMEOUT_SAMPLES first, go to ERROR with err_code=01.
- SAMPLE: on each adc_fe with ac_stable=1 and ac_period!=0, write ac_period into buffer slot 0..2.
  - ac_period=0 is skipped.
  - After the 3rd write, go to CHECK.
  - ac_stable=0 on any adc_fe: clear the buffer, go to WAIT_STABLE and clear the timeout counter.
- CHECK (1 cycle): spread = max-min as unsigned 16-bit.
  - spread<=TOL: median -> period_out, go to REPORT, clear retry count.
  - Otherwise increment retry; if retry==MAX_RETRY go to ERROR with err_code=10, else go to WAIT_STABLE with the buffer cleared.
- REPORT (1 cycle): period_valid=1, locked=1. Next state is HOLD if continuous=1, else IDLE. In IDLE ac_en=0 but locked and period_out are kept until the next start.
- HOLD: ac_en=1.
  - On adc_fe with ac_stable=1: if |ac_period-period_out|>TOL, set locked=0 and go to ARM. Otherwise clear the loss counter.
  - On adc_fe with ac_stable=0: increment the loss counter; at HOLD_LOSS, set locked=0 and go to WAIT_STABLE.
- ERROR: ac_en=0, locked=0, err_code held. start goes to ARM and clears err_code.
- dc_valid=0 in WAIT_STABLE, SAMPLE, CHECK or HOLD: next cycle ac_en=0, locked=0, go to ARM.
- Priority: rst > stop > dc_valid loss > timeout/stable/adc events. start outside IDLE/ERROR is ignored. stop also clears locked.
- Latency: start to ac_en=1 is RST_CYCLES+1 cycles when dc_valid=1. The third capture to period_valid is 2 clk cycles (CHECK, REPORT).

Test Plan:
- rst, continuous=0, dc_valid=1, start. Engine model raises stable after 50 adc edges with period=256. Required: ac_en low for exactly 4 cycles, then high; period_valid pulses once with period_out=256; locked=1; busy=0 after REPORT.
- Captures 255,258,256 → period_out=256. Next run with captures 250,256,262 (spread 12) three times → ERROR, err_code=10, ac_en=0.
- ac_stable held 0, TIMEOUT_SAMPLES=1000 → err_code=01 on the clk cycle of the 1000th adc falling edge; a later start clears it and re-arms.
- continuous=1, lock at 512, then the model switches to period 400 → locked falls, ac_en low 4 cycles, new period_valid with period_out=400.
- HOLD at 512, ac_stable low for 7 adc edges then high → stays locked; low for 8 edges → locked=0, state WAIT_STABLE. dc_valid dropped in HOLD → ac_en=0 next cycle, ARM.
- stop mid-SAMPLE → IDLE, busy=0, locked=0. rst asserted mid-WAIT_STABLE together with start → all outputs at reset values, start ignored.
